muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle 32-bit multiply / divide unit (MUL, MULH, MULHU, DIV, DIVU, MOD, MODU)
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   clear_pipeline in   abort the current operation, return to IDLE
//   mul_para       in   op select: 0/2 MUL, 1 MULH, 3 MULHU, 4 DIV, 5 DIVU, 6 MOD, 7 MODU
//   mul_initial    in   start request, sampled only while mul_ready=1
//   mul_rs0        in   operand A / dividend
//   mul_rs1        in   operand B / divisor
//   mul_ready      out  unit idle
//   mul_finished   out  mul_data valid, held until mul_ack
//   mul_data       out  result
//   mul_ack        in   result consumed
// Compile option: MULDIV_DIV_EARLY_EXIT_EN finishes trivial divides (divisor 0 or
// |dividend| < |divisor|) without running the 32-step loop.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_pipeline,
   input  logic [2:0]  mul_para,
   input  logic        mul_initial,
   input  logic [31:0] mul_rs0,
   input  logic [31:0] mul_rs1,
   output logic        mul_ready,
   output logic        mul_finished,
   output logic [31:0] mul_data,
   input  logic        mul_ack
);
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
   state_t state, state_nxt;
   logic [2:0]  op;
   logic [31:0] a, b, quo, dvs, rem, a_mag, b_mag, sub, q_fix, r_fix;
   logic [32:0] sh;
   logic [63:0] ax, bx, prod;
   logic [5:0]  cnt;
   logic        ge, early;
   // signed variants (MUL/MULH/DIV/MOD) all have op[0]=0 except MULH (1); MULHU is the only unsigned multiply
   assign ax    = (op == 3'd3) ? {32'b0, a} : {{32{a[31]}}, a};
   assign bx    = (op == 3'd3) ? {32'b0, b} : {{32{b[31]}}, b};
   assign prod  = ax * bx;
   assign a_mag = (~mul_para[0] & mul_rs0[31]) ? -mul_rs0 : mul_rs0;
   assign b_mag = (~mul_para[0] & mul_rs1[31]) ? -mul_rs1 : mul_rs1;
   // restoring step: shift next dividend bit into the partial remainder, subtract if it fits
   assign sh    = {rem, quo[31]};
   assign ge    = sh >= {1'b0, dvs};
   assign sub   = sh[31:0] - dvs;
   // divide by zero yields all-ones regardless of signs; the overflow case falls out of the magnitude path
   assign q_fix = (dvs == 32'd0) ? 32'hFFFF_FFFF : (~op[0] & (a[31] ^ b[31])) ? -quo : quo;
   assign r_fix = (~op[0] & a[31]) ? -rem : rem;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
   assign early = (dvs == 32'd0) || (quo < dvs);
`else
   assign early = 1'b0;
`endif
   assign mul_ready    = state == IDLE;
   assign mul_finished = state == DONE;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = mul_initial ? (mul_para[2] ? DIV : MUL) : IDLE;
         MUL:     state_nxt = DONE;
         DIV:     state_nxt = (early && cnt == 6'd0) ? DONE : (cnt == 6'd31) ? FIX : DIV;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = mul_ack ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
      if (clear_pipeline) state_nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op       <= 3'd0;
         a        <= 32'd0;
         b        <= 32'd0;
         quo      <= 32'd0;
         dvs      <= 32'd0;
         rem      <= 32'd0;
         cnt      <= 6'd0;
         mul_data <= 32'd0;
      end else if (!clear_pipeline) begin
         case (state)
            IDLE: if (mul_initial) begin
               op  <= mul_para;
               a   <= mul_rs0;
               b   <= mul_rs1;
               quo <= a_mag;
               dvs <= b_mag;
               rem <= 32'd0;
               cnt <= 6'd0;
            end
            MUL: mul_data <= op[0] ? prod[63:32] : prod[31:0];
            DIV: if (early && cnt == 6'd0) mul_data <= op[1] ? a : {32{dvs == 32'd0}};
            else begin
               rem <= ge ? sub : sh[31:0];
               quo <= {quo[30:0], ge};
               cnt <= cnt + 6'd1;
            end
            FIX: mul_data <= op[1] ? r_fix : q_fix;
            default: ;
         endcase
      end
endmodule
